// File: rtl/t_regfile_blk.sv
// T register file: registered jk read port with write-first bypass, scalar write port,
// and a block-transfer sequencer streaming consecutive entries to/from memory.
module t_regfile_blk #(
    parameter int WIDTH    = 64,
    parameter int DEPTH    = 64,
    parameter int LOGDEPTH = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [LOGDEPTH-1:0] i_jk_addr,
    output logic [WIDTH-1:0]    o_jk_data,
    input  logic [LOGDEPTH-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]    i_wr_data,
    input  logic                i_wr_en,
    input  logic                i_blk_start,
    input  logic                i_blk_dir,
    input  logic [LOGDEPTH-1:0] i_blk_addr,
    input  logic [LOGDEPTH:0]   i_blk_cnt,
    output logic                o_blk_busy,
    output logic                o_blk_done,
    output logic                o_blk_rd_valid,
    output logic [WIDTH-1:0]    o_blk_rd_data,
    input  logic                i_blk_rd_ready,
    input  logic                i_blk_wr_valid,
    input  logic [WIDTH-1:0]    i_blk_wr_data,
    output logic                o_blk_wr_ready
);

    typedef enum logic [1:0] {IDLE, RD_STREAM, WR_STREAM, DONE} state_t;

    state_t              state_q, state_d;
    logic [LOGDEPTH-1:0] addr_q, addr_d;
    logic [LOGDEPTH:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]    jk_data_q, jk_data_d;
    logic [WIDTH-1:0]    rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic                wr_ready_q, wr_ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [WIDTH-1:0]    mem [DEPTH];

    logic                blk_we;
    logic                scl_we;
    logic [LOGDEPTH-1:0] addr_inc;
    logic [LOGDEPTH-1:0] rd_sel;
    logic [WIDTH-1:0]    rd_fwd;
    logic [WIDTH-1:0]    jk_fwd;

    // Block write outranks the scalar port; a colliding scalar write is dropped.
    function automatic logic [WIDTH-1:0] fwd(
        input logic [LOGDEPTH-1:0] a,
        input logic [WIDTH-1:0]    stored,
        input logic                bwe,
        input logic [LOGDEPTH-1:0] baddr,
        input logic [WIDTH-1:0]    bdata,
        input logic                swe,
        input logic [LOGDEPTH-1:0] saddr,
        input logic [WIDTH-1:0]    sdata
    );
        if (bwe && baddr == a) begin
            return bdata;
        end else if (swe && saddr == a) begin
            return sdata;
        end
        return stored;
    endfunction

    assign blk_we   = (state_q == WR_STREAM) && wr_ready_q && i_blk_wr_valid;
    assign scl_we   = i_wr_en && !(blk_we && i_wr_addr == addr_q);
    assign addr_inc = addr_q + LOGDEPTH'(1);
    assign rd_sel   = (state_q == IDLE) ? i_blk_addr : addr_inc;

    assign rd_fwd = fwd(rd_sel, mem[rd_sel], blk_we, addr_q, i_blk_wr_data,
                        i_wr_en, i_wr_addr, i_wr_data);
    assign jk_fwd = fwd(i_jk_addr, mem[i_jk_addr], blk_we, addr_q, i_blk_wr_data,
                        i_wr_en, i_wr_addr, i_wr_data);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        wr_ready_d = wr_ready_q;
        jk_data_d  = jk_fwd;
        case (state_q)
            IDLE: begin
                if (i_blk_start) begin
                    if (i_blk_cnt == '0) begin
                        state_d = DONE;
                    end else begin
                        addr_d = i_blk_addr;
                        cnt_d  = i_blk_cnt;
                        if (i_blk_dir) begin
                            state_d    = WR_STREAM;
                            wr_ready_d = 1'b1;
                        end else begin
                            state_d    = RD_STREAM;
                            rd_valid_d = 1'b1;
                            rd_data_d  = rd_fwd;
                        end
                    end
                end
            end
            RD_STREAM: begin
                // The output register only reloads on a handshake, so stalled data is frozen.
                if (rd_valid_q && i_blk_rd_ready) begin
                    addr_d = addr_inc;
                    cnt_d  = cnt_q - (LOGDEPTH+1)'(1);
                    if (cnt_q == (LOGDEPTH+1)'(1)) begin
                        rd_valid_d = 1'b0;
                        state_d    = DONE;
                    end else begin
                        rd_data_d = rd_fwd;
                    end
                end
            end
            WR_STREAM: begin
                if (blk_we) begin
                    addr_d = addr_inc;
                    cnt_d  = cnt_q - (LOGDEPTH+1)'(1);
                    if (cnt_q == (LOGDEPTH+1)'(1)) begin
                        wr_ready_d = 1'b0;
                        state_d    = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            jk_data_q  <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            wr_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            jk_data_q  <= jk_data_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            wr_ready_q <= wr_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (scl_we) begin
            mem[i_wr_addr] <= i_wr_data;
        end
        if (blk_we) begin
            mem[addr_q] <= i_blk_wr_data;
        end
    end

    assign o_jk_data      = jk_data_q;
    assign o_blk_rd_data  = rd_data_q;
    assign o_blk_rd_valid = rd_valid_q;
    assign o_blk_wr_ready = wr_ready_q;
    assign o_blk_busy     = busy_q;
    assign o_blk_done     = done_q;

endmodule

// File: tb/tb_t_regfile_blk.sv
// Scoreboard bench for t_regfile_blk: stimulus pushes expectations, a negedge monitor
// pops and compares whatever the DUT presents.
module tb_t_regfile_blk;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  i_jk_addr = '0;
    logic [63:0] o_jk_data;
    logic [5:0]  i_wr_addr = '0;
    logic [63:0] i_wr_data = '0;
    logic        i_wr_en = 1'b0;
    logic        i_blk_start = 1'b0;
    logic        i_blk_dir = 1'b0;
    logic [5:0]  i_blk_addr = '0;
    logic [6:0]  i_blk_cnt = '0;
    logic        o_blk_busy;
    logic        o_blk_done;
    logic        o_blk_rd_valid;
    logic [63:0] o_blk_rd_data;
    logic        i_blk_rd_ready = 1'b0;
    logic        i_blk_wr_valid = 1'b0;
    logic [63:0] i_blk_wr_data = '0;
    logic        o_blk_wr_ready;

    t_regfile_blk #(.WIDTH(64), .DEPTH(64), .LOGDEPTH(6)) dut (
        .clk            (clk),
        .rst            (rst_n),
        .i_jk_addr      (i_jk_addr),
        .o_jk_data      (o_jk_data),
        .i_wr_addr      (i_wr_addr),
        .i_wr_data      (i_wr_data),
        .i_wr_en        (i_wr_en),
        .i_blk_start    (i_blk_start),
        .i_blk_dir      (i_blk_dir),
        .i_blk_addr     (i_blk_addr),
        .i_blk_cnt      (i_blk_cnt),
        .o_blk_busy     (o_blk_busy),
        .o_blk_done     (o_blk_done),
        .o_blk_rd_valid (o_blk_rd_valid),
        .o_blk_rd_data  (o_blk_rd_data),
        .i_blk_rd_ready (i_blk_rd_ready),
        .i_blk_wr_valid (i_blk_wr_valid),
        .i_blk_wr_data  (i_blk_wr_data),
        .o_blk_wr_ready (o_blk_wr_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          addr;
        logic [63:0] val;
    } jk_t;

    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    int          done_exp = 0;
    jk_t         jk_q[$];
    logic [63:0] rd_q[$];
    logic [63:0] model [64];
    jk_t         mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (jk_q.size() > 0 && jk_q[0].cyc == cyc) begin
                mon_e = jk_q.pop_front();
                chk($sformatf("jk[%0d]", mon_e.addr), o_jk_data, mon_e.val);
            end
            if (o_blk_rd_valid) begin
                if (rd_q.size() == 0) begin
                    chk("rd_unexpected_valid", {63'd0, o_blk_rd_valid}, 64'd0);
                end else if (i_blk_rd_ready) begin
                    chk("rd_data", o_blk_rd_data, rd_q.pop_front());
                end else begin
                    chk("rd_hold", o_blk_rd_data, rd_q[0]);
                end
            end
            if (o_blk_done) begin
                if (done_exp == 0) begin
                    chk("done_unexpected", {63'd0, o_blk_done}, 64'd0);
                end else begin
                    done_exp--;
                    chk("done_seen", {63'd0, o_blk_done}, 64'd1);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic swrite(input int a, input logic [63:0] d);
        i_wr_en = 1'b1; i_wr_addr = 6'(a); i_wr_data = d;
        tick();
        i_wr_en = 1'b0;
        model[a] = d;
    endtask

    task automatic jk_read(input int a);
        i_jk_addr = 6'(a);
        jk_q.push_back('{cyc: cyc + 1, addr: a, val: model[a]});
        tick();
    endtask

    task automatic blk_start(input logic dir, input int a, input int n);
        i_blk_start = 1'b1; i_blk_dir = dir; i_blk_addr = 6'(a); i_blk_cnt = 7'(n);
        tick();
        i_blk_start = 1'b0;
    endtask

    initial begin
        logic got;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_jk", o_jk_data, 64'd0);
        chk("rst_rd_data", o_blk_rd_data, 64'd0);
        chk("rst_ctrl", {60'd0, o_blk_rd_valid, o_blk_wr_ready, o_blk_busy, o_blk_done}, 64'd0);
        rst_n = 1'b1;
        tick();

        for (int k = 0; k < 64; k++) swrite(k, 64'(k));

        // Scalar write then read, and same-cycle bypass
        swrite(5, 64'h0123456789ABCDEF);
        jk_read(5);
        i_wr_en = 1'b1; i_wr_addr = 6'd9; i_wr_data = 64'hAA; model[9] = 64'hAA;
        jk_read(9);
        i_wr_en = 1'b0;
        jk_read(62);

        // Stream-out with back-pressure, a late write and an ignored start
        rd_q.push_back(model[62]); rd_q.push_back(model[63]);
        rd_q.push_back(model[0]);  rd_q.push_back(model[1]);
        done_exp++;
        blk_start(1'b0, 62, 4);
        i_wr_en = 1'b1; i_wr_addr = 6'd62; i_wr_data = 64'hDEAD;
        i_blk_start = 1'b1; i_blk_dir = 1'b1; i_blk_addr = 6'd0; i_blk_cnt = 7'd5;
        tick();
        i_wr_en = 1'b0; i_blk_start = 1'b0; model[62] = 64'hDEAD;
        repeat (2) tick();
        chk("rd_valid_stalled", {63'd0, o_blk_rd_valid}, 64'd1);
        i_blk_rd_ready = 1'b1;
        got = 1'b0;
        for (int w = 0; w < 10 && !got; w++) begin
            @(negedge clk);
            got = o_blk_done;
        end
        chk("rdout_done_busy", {62'd0, got, o_blk_busy}, 64'd3);
        @(negedge clk);
        chk("rdout_busy_fall", {62'd0, o_blk_busy, o_blk_done}, 64'd0);
        i_blk_rd_ready = 1'b0;
        tick();
        jk_read(62);

        // Stream-in of the whole file with gaps in valid, wrapping 63->0
        done_exp++;
        blk_start(1'b1, 10, 64);
        for (int i = 0; i < 64; i++) begin
            if (i % 5 == 3) begin
                i_blk_wr_valid = 1'b0;
                tick();
            end
            i_blk_wr_valid = 1'b1; i_blk_wr_data = 64'h1000 + 64'(i);
            got = 1'b0;
            for (int w = 0; w < 10 && !got; w++) begin
                @(negedge clk);
                got = o_blk_wr_ready;
            end
            if (!got) begin
                chk("wr_ready_timeout", 64'd0, 64'd1);
                break;
            end
            @(posedge clk);
            #1;
            model[(10 + i) % 64] = 64'h1000 + 64'(i);
        end
        i_blk_wr_valid = 1'b0;
        chk("wr_ready_drop", {62'd0, o_blk_wr_ready, o_blk_busy}, 64'd1);
        tick();
        for (int k = 0; k < 64; k++) jk_read(k);

        // Collision: block write beats scalar write to addr 20; scalar to 30 commits
        done_exp++;
        blk_start(1'b1, 20, 2);
        i_blk_wr_valid = 1'b1; i_blk_wr_data = 64'hB;
        i_wr_en = 1'b1; i_wr_addr = 6'd20; i_wr_data = 64'h5;
        model[20] = 64'hB;
        jk_read(20);
        i_blk_wr_data = 64'hC; i_wr_addr = 6'd30; i_wr_data = 64'h77;
        model[21] = 64'hC; model[30] = 64'h77;
        jk_read(30);
        i_blk_wr_valid = 1'b0; i_wr_en = 1'b0;
        tick();
        jk_read(20); jk_read(21); jk_read(30);

        // Count zero: done only, no stream activity even with valid/ready offered
        done_exp++;
        i_blk_wr_valid = 1'b1; i_blk_rd_ready = 1'b1;
        blk_start(1'b1, 7, 0);
        for (int w = 0; w < 3; w++) begin
            @(negedge clk);
            chk("cnt0_no_stream", {62'd0, o_blk_wr_ready, o_blk_rd_valid}, 64'd0);
        end
        i_blk_wr_valid = 1'b0; i_blk_rd_ready = 1'b0;
        tick();
        jk_read(7);

        // Reset mid-transfer with three entries still to go
        rd_q.push_back(model[40]); rd_q.push_back(model[41]); rd_q.push_back(model[42]);
        blk_start(1'b0, 40, 5);
        i_blk_rd_ready = 1'b1;
        repeat (2) tick();
        i_blk_rd_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_ctrl", {61'd0, o_blk_rd_valid, o_blk_busy, o_blk_done}, 64'd0);
        rd_q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        jk_read(40); jk_read(41); jk_read(42); jk_read(5);

        for (int w = 0; w < 20 && (jk_q.size() > 0 || done_exp > 0 || rd_q.size() > 0); w++) tick();
        repeat (3) tick();
        chk("drain_jk", 64'(jk_q.size()), 64'd0);
        chk("drain_done", 64'(done_exp), 64'd0);
        chk("drain_rd", 64'(rd_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
